// File: rtl/rf_mp_scoreboard_if.sv
// Bundles the issue/write-back side of the multi-port register file with its
// pending scoreboard: two write ports, two read ports, mark port, debug read.
interface rf_mp_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we0;
  logic [ADDR_W-1:0] wa0;
  logic [DATA_W-1:0] wd0;
  logic              we1;
  logic [ADDR_W-1:0] wa1;
  logic [DATA_W-1:0] wd1;
  logic [ADDR_W-1:0] ra0;
  logic [DATA_W-1:0] rd0;
  logic              rd0_busy;
  logic [ADDR_W-1:0] ra1;
  logic [DATA_W-1:0] rd1;
  logic              rd1_busy;
  logic              mark_en;
  logic [ADDR_W-1:0] mark_addr;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, ra0, ra1, mark_en, mark_addr, dbg_addr,
    input  rd0, rd0_busy, rd1, rd1_busy, dbg_data, pend_cnt
  );

  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, ra0, ra1, mark_en, mark_addr, dbg_addr,
    output rd0, rd0_busy, rd1, rd1_busy, dbg_data, pend_cnt
  );
endinterface

// File: rtl/rf_mp_scoreboard.sv
// Two-write/two-read register file with fixed write priority, optional
// same-cycle bypass, per-register pending scoreboard and a debug read port.
module rf_mp_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic               clk,
  input logic               rst_n,
  rf_mp_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]            r_regs [DEPTH];
  logic [DEPTH-1:0]             r_pend;
  logic [ADDR_W:0]              r_pend_cnt;

  logic                         w_wr0;
  logic                         w_wr1;
  logic                         w_mark;
  logic                         w_byp0;
  logic                         w_byp1;
  logic [DEPTH-1:0]             w_pend_nxt;
  logic [ADDR_W:0]              w_cnt_nxt;
  logic [1:0][ADDR_W-1:0]       w_ra;
  logic [1:0][DATA_W-1:0]       w_rd;
  logic [1:0]                   w_busy;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign w_wr0  = bus.we0 && !is_zero(bus.wa0);
  assign w_wr1  = bus.we1 && !is_zero(bus.wa1);
  assign w_mark = bus.mark_en && !is_zero(bus.mark_addr);
  // A write presented during reset is discarded, so it must not be bypassed either.
  assign w_byp0 = w_wr0 && rst_n;
  assign w_byp1 = w_wr1 && rst_n;

  assign w_ra[0] = bus.ra0;
  assign w_ra[1] = bus.ra1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd[p]   = r_regs[w_ra[p]];
      w_busy[p] = r_pend[w_ra[p]];
      if (BYPASS != 0) begin
        if (w_byp1 && (bus.wa1 == w_ra[p])) begin
          w_rd[p]   = bus.wd1;
          w_busy[p] = 1'b0;
        end else if (w_byp0 && (bus.wa0 == w_ra[p])) begin
          w_rd[p]   = bus.wd0;
          w_busy[p] = 1'b0;
        end
      end
      if (is_zero(w_ra[p])) begin
        w_rd[p]   = '0;
        w_busy[p] = 1'b0;
      end
    end
  end

  // Clears from write-back first, then the issue mark, so a new producer wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr0)  w_pend_nxt[bus.wa0]       = 1'b0;
    if (w_wr1)  w_pend_nxt[bus.wa1]       = 1'b0;
    if (w_mark) w_pend_nxt[bus.mark_addr] = 1'b1;
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_pend_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_wr0) r_regs[bus.wa0] <= bus.wd0;
      if (w_wr1) r_regs[bus.wa1] <= bus.wd1;
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_cnt_nxt;
    end
  end

  assign bus.rd0      = w_rd[0];
  assign bus.rd0_busy = w_busy[0];
  assign bus.rd1      = w_rd[1];
  assign bus.rd1_busy = w_busy[1];
  assign bus.dbg_data = r_regs[bus.dbg_addr];
  assign bus.pend_cnt = r_pend_cnt;
endmodule

// File: tb/tb_rf_mp_scoreboard.sv
// Bench for rf_mp_scoreboard: vector table, reset/bypass-off sequences and a
// randomised run against a reference model with a pend_cnt queue.
module tb_rf_mp_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rf_mp_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bi ();
  rf_mp_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bz ();

  rf_mp_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .bus(bi));
  rf_mp_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .bus(bz));

  typedef struct {
    bit [31:0] we0, wa0, wd0, we1, wa1, wd1, ra0, ra1, mk, ma, da;
    bit [31:0] e_rd0, e_b0, e_rd1, e_b1, e_dbg, e_cnt;
  } vec_t;

  localparam int NV = 16;
  vec_t          tv [NV];
  logic [5:0]    q_cnt [$];
  logic [31:0]   m_reg [32];
  logic [31:0]   m_pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_bi();
    bi.we0 = 1'b0; bi.we1 = 1'b0; bi.mark_en = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    bi.we0 = v.we0[0]; bi.wa0 = v.wa0[4:0]; bi.wd0 = v.wd0;
    bi.we1 = v.we1[0]; bi.wa1 = v.wa1[4:0]; bi.wd1 = v.wd1;
    bi.ra0 = v.ra0[4:0]; bi.ra1 = v.ra1[4:0];
    bi.mark_en = v.mk[0]; bi.mark_addr = v.ma[4:0]; bi.dbg_addr = v.da[4:0];
  endtask

  task automatic pop_cnt(input string nm);
    logic [5:0] e;
    if (q_cnt.size() == 0) begin
      chk({nm, " queue"}, 32'd0, 32'd1);
    end else begin
      e = q_cnt.pop_front();
      chk(nm, {26'd0, bi.pend_cnt}, {26'd0, e});
    end
  endtask

  function automatic void mexp(input logic [4:0] ra, output logic [31:0] d, output logic b);
    if (ra == 5'd0) begin
      d = 32'd0; b = 1'b0;
    end else if (bi.we1 && bi.wa1 == ra) begin
      d = bi.wd1; b = 1'b0;
    end else if (bi.we0 && bi.wa0 == ra) begin
      d = bi.wd0; b = 1'b0;
    end else begin
      d = m_reg[ra]; b = m_pend[ra];
    end
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ed;
    logic        eb;

    tv[0]  = '{0,0,0,        0,0,0,          0,0,   0,0,  0,  0,0,       0,0,       0,      0};
    tv[1]  = '{1,3,'h11,     1,3,'h22,       3,3,   0,0,  3,  'h22,0,    'h22,0,    0,      0};
    tv[2]  = '{0,0,0,        0,0,0,          3,0,   0,0,  3,  'h22,0,    0,0,       'h22,   0};
    tv[3]  = '{0,0,0,        1,0,'hFFFFFFFF, 0,3,   1,0,  0,  0,0,       'h22,0,    0,      0};
    tv[4]  = '{0,0,0,        0,0,0,          7,7,   1,7,  7,  0,0,       0,0,       0,      1};
    tv[5]  = '{0,0,0,        0,0,0,          3,7,   0,0,  7,  'h22,0,    0,1,       0,      1};
    tv[6]  = '{1,7,'h1234,   0,0,0,          7,7,   0,0,  7,  'h1234,0,  'h1234,0,  0,      0};
    tv[7]  = '{0,0,0,        0,0,0,          7,7,   0,0,  7,  'h1234,0,  'h1234,0,  'h1234, 0};
    tv[8]  = '{1,9,'h99,     0,0,0,          9,9,   1,9,  9,  'h99,0,    'h99,0,    0,      1};
    tv[9]  = '{0,0,0,        0,0,0,          9,9,   0,0,  9,  'h99,1,    'h99,1,    'h99,   1};
    tv[10] = '{0,0,0,        0,0,0,          9,7,   1,9,  9,  'h99,1,    'h1234,0,  'h99,   1};
    tv[11] = '{0,0,0,        1,9,'hAA,       9,10,  1,10, 9,  'hAA,0,    0,0,       'h99,   1};
    tv[12] = '{1,10,'h55,    1,11,'h66,      10,11, 0,0,  10, 'h55,0,    'h66,0,    0,      0};
    tv[13] = '{0,0,0,        0,0,0,          10,11, 0,0,  11, 'h55,0,    'h66,0,    'h66,   0};
    tv[14] = '{0,0,0,        0,0,0,          31,9,  1,31, 31, 0,0,       'hAA,0,    0,      1};
    tv[15] = '{0,0,0,        0,0,0,          31,9,  0,0,  31, 0,1,       'hAA,0,    0,      1};

    drive(tv[0]);
    bz.we0 = 1'b0; bz.wa0 = '0; bz.wd0 = '0; bz.we1 = 1'b0; bz.wa1 = '0; bz.wd1 = '0;
    bz.ra0 = '0; bz.ra1 = '0; bz.mark_en = 1'b0; bz.mark_addr = '0; bz.dbg_addr = '0;

    // Power-on reset
    bi.ra0 = 5'd5; bi.we1 = 1'b1; bi.wa1 = 5'd5; bi.wd1 = 32'h1; bi.mark_en = 1'b1; bi.mark_addr = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rd0", bi.rd0, 32'd0);
    chk("reset pend_cnt", {26'd0, bi.pend_cnt}, 32'd0);
    @(negedge clk);
    drive(tv[0]);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d rd0", i), bi.rd0, tv[i].e_rd0);
      chk($sformatf("v%0d rd0_busy", i), {31'd0, bi.rd0_busy}, tv[i].e_b0);
      chk($sformatf("v%0d rd1", i), bi.rd1, tv[i].e_rd1);
      chk($sformatf("v%0d rd1_busy", i), {31'd0, bi.rd1_busy}, tv[i].e_b1);
      chk($sformatf("v%0d dbg", i), bi.dbg_data, tv[i].e_dbg);
      q_cnt.push_back(tv[i].e_cnt[5:0]);
      @(posedge clk);
      #1;
      pop_cnt($sformatf("v%0d pend_cnt", i));
    end

    // Bypass disabled: same-cycle reads see the old contents
    @(negedge clk);
    bz.we0 = 1'b1; bz.wa0 = 5'd4; bz.wd0 = 32'hA5; bz.ra0 = 5'd4;
    #1;
    chk("nobyp rd0 same cycle", bz.rd0, 32'd0);
    @(negedge clk);
    bz.we0 = 1'b0;
    #1;
    chk("nobyp rd0 next cycle", bz.rd0, 32'hA5);
    @(negedge clk);
    bz.we0 = 1'b1; bz.wa0 = 5'd3; bz.wd0 = 32'h11;
    bz.we1 = 1'b1; bz.wa1 = 5'd3; bz.wd1 = 32'h22; bz.ra0 = 5'd3; bz.dbg_addr = 5'd3;
    #1;
    chk("nobyp conflict same cycle", bz.rd0, 32'd0);
    @(negedge clk);
    bz.we0 = 1'b0; bz.we1 = 1'b0;
    #1;
    chk("nobyp conflict dbg", bz.dbg_data, 32'h22);

    // Mid-run asynchronous reset
    @(negedge clk);
    bi.we0 = 1'b0; bi.we1 = 1'b1; bi.wa1 = 5'd5; bi.wd1 = 32'hDEADBEEF;
    bi.mark_en = 1'b1; bi.mark_addr = 5'd12;
    @(posedge clk);
    #1;
    idle_bi();
    bi.ra0 = 5'd5; bi.dbg_addr = 5'd5; bi.ra1 = 5'd12;
    #1;
    chk("pre-reset rd0", bi.rd0, 32'hDEADBEEF);
    chk("pre-reset dbg", bi.dbg_data, 32'hDEADBEEF);
    chk("pre-reset pend_cnt", {26'd0, bi.pend_cnt}, 32'd2);
    chk("pre-reset rd1_busy", {31'd0, bi.rd1_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("in-reset rd0", bi.rd0, 32'd0);
    chk("in-reset dbg", bi.dbg_data, 32'd0);
    chk("in-reset pend_cnt", {26'd0, bi.pend_cnt}, 32'd0);
    chk("in-reset rd1_busy", {31'd0, bi.rd1_busy}, 32'd0);
    bi.we1 = 1'b1; bi.wa1 = 5'd6; bi.wd1 = 32'h77;
    bi.mark_en = 1'b1; bi.mark_addr = 5'd6; bi.dbg_addr = 5'd6;
    @(posedge clk);
    #1;
    chk("in-reset write dropped", bi.dbg_data, 32'd0);
    chk("in-reset mark dropped", {26'd0, bi.pend_cnt}, 32'd0);
    @(negedge clk);
    idle_bi();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset dbg", bi.dbg_data, 32'd0);
    chk("post-reset rd0", bi.rd0, 32'd0);
    chk("post-reset pend_cnt", {26'd0, bi.pend_cnt}, 32'd0);
    chk("post-reset rd1_busy", {31'd0, bi.rd1_busy}, 32'd0);

    // Randomised traffic against the reference model
    for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;
    m_pend = 32'd0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      bi.we0 = 1'($urandom_range(0, 1)); bi.wa0 = 5'($urandom_range(0, 7)); bi.wd0 = $urandom;
      bi.we1 = 1'($urandom_range(0, 1)); bi.wa1 = 5'($urandom_range(0, 7)); bi.wd1 = $urandom;
      bi.mark_en = 1'($urandom_range(0, 1)); bi.mark_addr = 5'($urandom_range(0, 7));
      bi.ra0 = 5'($urandom_range(0, 7)); bi.ra1 = 5'($urandom_range(0, 7));
      bi.dbg_addr = 5'($urandom_range(0, 7));
      #1;
      mexp(bi.ra0, ed, eb);
      chk($sformatf("rnd%0d rd0", c), bi.rd0, ed);
      chk($sformatf("rnd%0d rd0_busy", c), {31'd0, bi.rd0_busy}, {31'd0, eb});
      mexp(bi.ra1, ed, eb);
      chk($sformatf("rnd%0d rd1", c), bi.rd1, ed);
      chk($sformatf("rnd%0d rd1_busy", c), {31'd0, bi.rd1_busy}, {31'd0, eb});
      chk($sformatf("rnd%0d dbg", c), bi.dbg_data, m_reg[bi.dbg_addr]);
      if (bi.we0 && bi.wa0 != 5'd0) begin m_reg[bi.wa0] = bi.wd0; m_pend[bi.wa0] = 1'b0; end
      if (bi.we1 && bi.wa1 != 5'd0) begin m_reg[bi.wa1] = bi.wd1; m_pend[bi.wa1] = 1'b0; end
      if (bi.mark_en && bi.mark_addr != 5'd0) m_pend[bi.mark_addr] = 1'b1;
      q_cnt.push_back(6'($countones(m_pend)));
      @(posedge clk);
      #1;
      pop_cnt($sformatf("rnd%0d pend_cnt", c));
    end
    idle_bi();

    chk("queue drained", q_cnt.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
